relu_maxpool_stream: RTL and testbench

//  Downstream neighbour of the convolution stage: takes one feature map of signed conv results,

---
 rtl/cnn_pkg.sv | 33 +++
 rtl/relu_maxpool_stream.sv | 115 +++++++++++
 tb/tb_relu_maxpool_stream.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN pipeline: layer geometry, data widths and
// the ReLU/truncate helper used wherever a signed conv result becomes an
// unsigned activation.
package cnn_pkg;

  // Convolution stage output geometry and width
  localparam int CONV_SIZE = 45;
  localparam int CONV_X    = 24;
  localparam int CONV_Y    = 24;

  // Pooled map geometry; the sign bit is dropped after ReLU
  localparam int POOL_X    = 12;
  localparam int POOL_Y    = 12;
  localparam int POOL_SIZE = CONV_SIZE - 1;

  typedef logic signed [CONV_SIZE-1:0] conv_t;
  typedef logic        [POOL_SIZE-1:0] pool_t;

  // Position of a pixel inside its 2x2 pooling window, encoded as
  // {row parity, column parity}
  typedef enum logic [1:0] {
    PH_HOLD_FIRST = 2'b00,  // top-left: start a new partial max
    PH_LBUF_WRITE = 2'b01,  // top-right: park the top-row max in the line buffer
    PH_HOLD_MERGE = 2'b10,  // bottom-left: pick up the parked max
    PH_EMIT       = 2'b11   // bottom-right: window complete
  } pool_phase_t;

  // Negative values clamp to zero; non-negative values lose their sign bit
  function automatic pool_t relu_trunc(input conv_t v);
    return v[CONV_SIZE-1] ? '0 : v[POOL_SIZE-1:0];
  endfunction

endpackage

// File: rtl/relu_maxpool_stream.sv
// ReLU followed by 2x2/stride-2 max pooling over a raster-ordered stream of
// signed conv results. Only half a row of partial maxima is kept: the top row
// of each window is reduced into the line buffer, the bottom row merges with
// it and emits one pooled value per window.
module relu_maxpool_stream
  import cnn_pkg::*;
#(
  parameter int IN_W  = CONV_SIZE,
  parameter int IMG_X = CONV_X,
  parameter int IMG_Y = CONV_Y,
  parameter int OUT_W = IN_W - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last
);

  localparam int RW     = $clog2(IMG_X);
  localparam int CW     = $clog2(IMG_Y);
  localparam int HALF_Y = IMG_Y / 2;
  localparam int LW     = $clog2(HALF_Y);

  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_X - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_Y - 1);

  logic [RW-1:0]    row;
  logic [CW-1:0]    col;
  logic [OUT_W-1:0] hold;
  logic [OUT_W-1:0] lbuf [HALF_Y];

  logic             accept;
  logic             frame_end;
  logic [OUT_W-1:0] pix;
  logic [OUT_W-1:0] lbuf_rd;
  logic [LW-1:0]    lidx;
  pool_phase_t      phase;

  // Sign bit selects zero, otherwise keep the magnitude bits
  function automatic logic [OUT_W-1:0] relu(input logic [IN_W-1:0] v);
    return v[IN_W-1] ? '0 : v[OUT_W-1:0];
  endfunction

  // Unsigned maximum; on a tie both operands are the same value
  function automatic logic [OUT_W-1:0] max2(input logic [OUT_W-1:0] a,
                                            input logic [OUT_W-1:0] b);
    return (a >= b) ? a : b;
  endfunction

  // The input may only advance when the output register is free or draining
  assign in_ready  = !out_valid | out_ready;
  assign accept    = in_valid & in_ready;

  assign pix       = relu(in_data);
  assign phase     = pool_phase_t'({row[0], col[0]});
  assign lidx      = LW'(col >> 1);
  assign lbuf_rd   = lbuf[lidx];
  assign frame_end = (row == ROW_LAST) && (col == COL_LAST);

  // Raster position of the next pixel; frames follow each other with no gap
  always_ff @(posedge clk) begin
    if (rst) begin
      row <= '0;
      col <= '0;
    end else if (accept) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Top-row pairs are reduced and parked, one entry per pooled column
  always_ff @(posedge clk) begin
    if (!rst && accept && phase == PH_LBUF_WRITE) begin
      lbuf[lidx] <= max2(hold, pix);
    end
  end

  // Partial max tracking and the registered output stage; a drain and a new
  // pooled value in the same cycle keep out_valid high with the new value
  always_ff @(posedge clk) begin
    if (rst) begin
      hold      <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
      if (accept) begin
        case (phase)
          PH_HOLD_FIRST: hold <= pix;
          PH_HOLD_MERGE: hold <= max2(lbuf_rd, pix);
          PH_EMIT: begin
            out_data  <= max2(hold, pix);
            out_valid <= 1'b1;
            out_last  <= frame_end;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_relu_maxpool_stream.sv
// Directed bench for relu_maxpool_stream: ramp frames, ReLU clamping,
// hand-built pooling windows, output stall, back-to-back frames and a
// mid-frame reset.
module tb_relu_maxpool_stream;

  localparam int IN_W  = 45;
  localparam int OUT_W = 44;
  localparam int NPIX  = 576;
  localparam int NOUT  = 144;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_last;

  int vectors     = 0;
  int miscompares = 0;

  logic [IN_W-1:0] px [NPIX];
  logic [OUT_W:0]  q [$];

  always #5 clk = ~clk;

  relu_maxpool_stream dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  // Hard stop if something wedges the run
  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time exceeded");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [OUT_W-1:0] relu_ref(input logic [IN_W-1:0] v);
    if (v[IN_W-1]) return '0;
    return v[OUT_W-1:0];
  endfunction

  // Max of the four ReLU'd pixels of pooled window k
  function automatic logic [OUT_W-1:0] pool_ref(input int k);
    int i = k / 12;
    int j = k % 12;
    logic [OUT_W-1:0] m = '0;
    logic [OUT_W-1:0] v;
    for (int a = 0; a < 2; a++)
      for (int b = 0; b < 2; b++) begin
        v = relu_ref(px[(2*i+a)*24 + 2*j + b]);
        if (v > m) m = v;
      end
    return m;
  endfunction

  function automatic int ramp_out(input int k);
    return (2*(k/12)+1)*24 + 2*(k%12) + 1;
  endfunction

  // One clock: drive, sample handshake on the falling edge, then pass the rising edge
  task automatic step(input logic v, input logic [IN_W-1:0] d, input logic ordy,
                      output logic acc);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    @(negedge clk);
    acc = v & in_ready & ~rst;
    if (out_valid && ordy && !rst) q.push_back({out_last, out_data});
    @(posedge clk);
    #1;
  endtask

  // Stream px with the output always ready, then let the last result drain
  task automatic feed_frame();
    int   idx = 0;
    int   cyc = 0;
    logic acc;
    while (idx < NPIX && cyc < 4*NPIX) begin
      step(1'b1, px[idx], 1'b1, acc);
      if (acc) idx++;
      cyc++;
    end
    if (idx < NPIX) begin
      vectors++; miscompares++;
      $display("[TB] FAIL feed_timeout: accepted %0d pixels, expected %0d", idx, NPIX);
    end
    repeat (4) step(1'b0, '0, 1'b1, acc);
  endtask

  task automatic test_reset();
    logic acc;
    rst = 1'b1;
    step(1'b1, 45'd77, 1'b0, acc);
    step(1'b1, 45'd77, 1'b1, acc);
    rst = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_valid: got %b, expected 0", out_valid); end
    vectors++;
    if (out_last !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_last: got %b, expected 0", out_last); end
    vectors++;
    if (out_data !== '0) begin miscompares++; $display("[TB] FAIL reset_out_data: got %0h, expected 0", out_data); end
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_in_ready: got %b, expected 1", in_ready); end
  endtask

  task automatic test_ramp();
    int   idx = 0;
    int   cyc = 0;
    logic acc;
    q.delete();
    for (int k = 0; k < NPIX; k++) px[k] = IN_W'(k);
    while (idx < NPIX && cyc < 4*NPIX) begin
      step(1'b1, px[idx], 1'b1, acc);
      if (acc) begin
        if (idx == 24) begin
          vectors++;
          if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL early_valid: got %b, expected 0", out_valid); end
        end
        if (idx == 25) begin
          vectors++;
          if (out_valid !== 1'b1 || out_data !== 44'd25) begin
            miscompares++;
            $display("[TB] FAIL first_latency: got valid=%b data=%0d, expected valid=1 data=25", out_valid, out_data);
          end
        end
        idx++;
      end
      cyc++;
    end
    repeat (4) step(1'b0, '0, 1'b1, acc);
    vectors++;
    if (q.size() != NOUT) begin miscompares++; $display("[TB] FAIL ramp_count: got %0d, expected %0d", q.size(), NOUT); end
    for (int k = 0; k < NOUT && k < q.size(); k++) begin
      vectors++;
      if (q[k][OUT_W-1:0] !== OUT_W'(ramp_out(k)) || q[k][OUT_W] !== (k == NOUT-1)) begin
        miscompares++;
        $display("[TB] FAIL ramp_out[%0d]: got last=%b data=%0d, expected last=%b data=%0d",
                 k, q[k][OUT_W], q[k][OUT_W-1:0], (k == NOUT-1), ramp_out(k));
      end
    end
  endtask

  task automatic test_relu();
    q.delete();
    for (int k = 0; k < NPIX; k++) px[k] = -45'd5;
    feed_frame();
    vectors++;
    if (q.size() != NOUT) begin miscompares++; $display("[TB] FAIL neg5_count: got %0d, expected %0d", q.size(), NOUT); end
    for (int k = 0; k < q.size(); k++) begin
      vectors++;
      if (q[k] !== {(k == NOUT-1), 44'd0}) begin
        miscompares++;
        $display("[TB] FAIL neg5_out[%0d]: got %0h, expected last=%b data=0", k, q[k], (k == NOUT-1));
      end
    end
    q.delete();
    for (int k = 0; k < NPIX; k++) px[k] = -45'd1;
    px[0] = 45'h1000_0000_0000;
    feed_frame();
    vectors++;
    if (q.size() != NOUT) begin
      miscompares++; $display("[TB] FAIL minneg_count: got %0d, expected %0d", q.size(), NOUT);
    end else if (q[0][OUT_W-1:0] !== 44'd0) begin
      miscompares++; $display("[TB] FAIL minneg_out0: got %0h, expected 0", q[0][OUT_W-1:0]);
    end
  endtask

  task automatic test_block();
    logic [OUT_W-1:0] hand [4];
    q.delete();
    for (int k = 0; k < NPIX; k++) px[k] = '0;
    px[0]  = 45'd7;  px[1]  = 45'd3;  px[24] = 45'd9;   px[25] = 45'd2;
    px[2]  = -45'd1; px[3]  = 45'd4;  px[26] = -45'd8;  px[27] = -45'd2;
    px[4]  = 45'd5;  px[5]  = 45'd5;  px[28] = 45'd5;   px[29] = 45'd5;
    px[22*24+22] = 45'h0FFF_FFFF_FFFF;
    px[23*24+23] = 45'h0FFF_FFFF_FFFF;
    hand[0] = 44'd9; hand[1] = 44'd4; hand[2] = 44'd5; hand[3] = 44'hFFF_FFFF_FFFF;
    feed_frame();
    vectors++;
    if (q.size() != NOUT) begin miscompares++; $display("[TB] FAIL block_count: got %0d, expected %0d", q.size(), NOUT); end
    if (q.size() == NOUT) begin
      for (int h = 0; h < 4; h++) begin
        int k = (h == 3) ? NOUT-1 : h;
        vectors++;
        if (q[k][OUT_W-1:0] !== hand[h]) begin
          miscompares++;
          $display("[TB] FAIL block_hand[%0d]: got %0h, expected %0h", k, q[k][OUT_W-1:0], hand[h]);
        end
      end
      for (int k = 0; k < NOUT; k++) begin
        vectors++;
        if (q[k] !== {(k == NOUT-1), pool_ref(k)}) begin
          miscompares++;
          $display("[TB] FAIL block_out[%0d]: got %0h, expected %0h", k, q[k], {(k == NOUT-1), pool_ref(k)});
        end
      end
    end
  endtask

  task automatic test_stall();
    int   idx = 0;
    int   cyc = 0;
    int   stalled = 0;
    bit   seen = 0;
    logic ordy;
    logic acc;
    q.delete();
    for (int k = 0; k < NPIX; k++) px[k] = IN_W'(k);
    while (idx < NPIX && cyc < 4*NPIX) begin
      if (!seen && out_valid) seen = 1;
      ordy = !(seen && stalled < 10);
      step(1'b1, px[idx], ordy, acc);
      if (acc) idx++;
      if (!ordy) begin
        stalled++;
        vectors++;
        if (in_ready !== 1'b0 || acc !== 1'b0) begin
          miscompares++; $display("[TB] FAIL stall_in_ready[%0d]: got %b, expected 0", stalled, in_ready);
        end
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 44'd25) begin
          miscompares++;
          $display("[TB] FAIL stall_hold[%0d]: got valid=%b data=%0d, expected valid=1 data=25", stalled, out_valid, out_data);
        end
      end
      cyc++;
    end
    repeat (4) step(1'b0, '0, 1'b1, acc);
    vectors++;
    if (stalled != 10 || q.size() != NOUT) begin
      miscompares++; $display("[TB] FAIL stall_count: got stalls=%0d outputs=%0d, expected 10 and %0d", stalled, q.size(), NOUT);
    end
    for (int k = 0; k < NOUT && k < q.size(); k++) begin
      vectors++;
      if (q[k] !== {(k == NOUT-1), OUT_W'(ramp_out(k))}) begin
        miscompares++;
        $display("[TB] FAIL stall_out[%0d]: got %0d, expected %0d", k, q[k][OUT_W-1:0], ramp_out(k));
      end
    end
  endtask

  task automatic test_back_to_back();
    int   idx = 0;
    int   cyc = 0;
    int   exp_v;
    logic acc;
    q.delete();
    while (idx < 2*NPIX && cyc < 8*NPIX) begin
      step(1'b1, (idx < NPIX) ? IN_W'(idx) : IN_W'(3*(idx-NPIX)), 1'b1, acc);
      if (acc) idx++;
      cyc++;
    end
    repeat (4) step(1'b0, '0, 1'b1, acc);
    vectors++;
    if (cyc != 2*NPIX) begin miscompares++; $display("[TB] FAIL b2b_cycles: got %0d, expected %0d", cyc, 2*NPIX); end
    vectors++;
    if (q.size() != 2*NOUT) begin miscompares++; $display("[TB] FAIL b2b_count: got %0d, expected %0d", q.size(), 2*NOUT); end
    for (int k = 0; k < 2*NOUT && k < q.size(); k++) begin
      exp_v = (k < NOUT) ? ramp_out(k) : 3*ramp_out(k-NOUT);
      vectors++;
      if (q[k] !== {(k == NOUT-1 || k == 2*NOUT-1), OUT_W'(exp_v)}) begin
        miscompares++;
        $display("[TB] FAIL b2b_out[%0d]: got last=%b data=%0d, expected last=%b data=%0d",
                 k, q[k][OUT_W], q[k][OUT_W-1:0], (k == NOUT-1 || k == 2*NOUT-1), exp_v);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic acc;
    for (int k = 0; k < 300; k++) step(1'b1, IN_W'(k + 5000), 1'b1, acc);
    rst = 1'b1;
    step(1'b1, 45'd9999, 1'b1, acc);
    rst = 1'b0;
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset_valid: got %b, expected 0", out_valid); end
    q.delete();
    for (int k = 0; k < NPIX; k++) px[k] = IN_W'(k);
    feed_frame();
    vectors++;
    if (q.size() != NOUT) begin miscompares++; $display("[TB] FAIL midreset_count: got %0d, expected %0d", q.size(), NOUT); end
    for (int k = 0; k < NOUT && k < q.size(); k++) begin
      vectors++;
      if (q[k] !== {(k == NOUT-1), OUT_W'(ramp_out(k))}) begin
        miscompares++;
        $display("[TB] FAIL midreset_out[%0d]: got %0d, expected %0d", k, q[k][OUT_W-1:0], ramp_out(k));
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_ramp();
    test_relu();
    test_block();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
